// File: rtl/z88_kbd_pkg.sv
// rtl/z88_kbd_pkg.sv - shared receiver states, byte constants and PS/2 set-2 to Z88 matrix table
package z88_kbd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // mck cycles without a PS/2 clock edge before a frame is abandoned
  localparam int unsigned RX_TIMEOUT = 10000;

  localparam logic [7:0] BYTE_EXT    = 8'hE0;
  localparam logic [7:0] BYTE_BRK    = 8'hF0;
  localparam logic [7:0] BYTE_PAUSE  = 8'hE1;
  localparam logic [7:0] BYTE_OVR0   = 8'h00;
  localparam logic [7:0] BYTE_OVR1   = 8'hFF;
  localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_ECHO   = 8'hEE;
  localparam logic [7:0] BYTE_BAT_NG = 8'hFC;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;

  // Pause sends E1 followed by seven bytes that carry no key information
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
  } scan_ent_t;

  // {ext, code} -> matrix bit 8*row+col; row 0 is A8, col is the data bit
  function automatic scan_ent_t scan_lookup(input logic [8:0] key);
    scan_ent_t e;
    e = '{valid: 1'b0, idx: 6'd0};
    case (key)
      // row A8: 8 7 N H Y 6 ENTER DEL
      9'h03E: e = '{1'b1, 6'd0};
      9'h075: e = '{1'b1, 6'd0};   // keypad 8 doubles as '8'
      9'h03D: e = '{1'b1, 6'd1};
      9'h031: e = '{1'b1, 6'd2};
      9'h033: e = '{1'b1, 6'd3};
      9'h035: e = '{1'b1, 6'd4};
      9'h036: e = '{1'b1, 6'd5};
      9'h05A: e = '{1'b1, 6'd6};
      9'h15A: e = '{1'b1, 6'd6};   // keypad enter
      9'h066: e = '{1'b1, 6'd7};
      // row A9: I U B G T 5 UP backslash
      9'h043: e = '{1'b1, 6'd8};
      9'h03C: e = '{1'b1, 6'd9};
      9'h032: e = '{1'b1, 6'd10};
      9'h034: e = '{1'b1, 6'd11};
      9'h02C: e = '{1'b1, 6'd12};
      9'h02E: e = '{1'b1, 6'd13};
      9'h175: e = '{1'b1, 6'd14};
      9'h05D: e = '{1'b1, 6'd15};
      // row A10: O J V F R 4 DOWN =
      9'h044: e = '{1'b1, 6'd16};
      9'h03B: e = '{1'b1, 6'd17};
      9'h02A: e = '{1'b1, 6'd18};
      9'h02B: e = '{1'b1, 6'd19};
      9'h02D: e = '{1'b1, 6'd20};
      9'h025: e = '{1'b1, 6'd21};
      9'h172: e = '{1'b1, 6'd22};
      9'h055: e = '{1'b1, 6'd23};
      // row A11: 9 K C D E 3 RIGHT -
      9'h046: e = '{1'b1, 6'd24};
      9'h042: e = '{1'b1, 6'd25};
      9'h021: e = '{1'b1, 6'd26};
      9'h023: e = '{1'b1, 6'd27};
      9'h024: e = '{1'b1, 6'd28};
      9'h026: e = '{1'b1, 6'd29};
      9'h174: e = '{1'b1, 6'd30};
      9'h04E: e = '{1'b1, 6'd31};
      // row A12: P M X S W 2 LEFT ]
      9'h04D: e = '{1'b1, 6'd32};
      9'h03A: e = '{1'b1, 6'd33};
      9'h022: e = '{1'b1, 6'd34};
      9'h01B: e = '{1'b1, 6'd35};
      9'h01D: e = '{1'b1, 6'd36};
      9'h01E: e = '{1'b1, 6'd37};
      9'h16B: e = '{1'b1, 6'd38};
      9'h05B: e = '{1'b1, 6'd39};
      // row A13: 0 L Z A Q 1 SPACE [
      9'h045: e = '{1'b1, 6'd40};
      9'h04B: e = '{1'b1, 6'd41};
      9'h01A: e = '{1'b1, 6'd42};
      9'h01C: e = '{1'b1, 6'd43};
      9'h015: e = '{1'b1, 6'd44};
      9'h016: e = '{1'b1, 6'd45};
      9'h029: e = '{1'b1, 6'd46};
      9'h054: e = '{1'b1, 6'd47};
      // row A14: ' ; , MENU(F2) DIAMOND(LCTRL) TAB LSHIFT HELP(F1)
      9'h052: e = '{1'b1, 6'd48};
      9'h04C: e = '{1'b1, 6'd49};
      9'h041: e = '{1'b1, 6'd50};
      9'h006: e = '{1'b1, 6'd51};
      9'h014: e = '{1'b1, 6'd52};
      9'h00D: e = '{1'b1, 6'd53};
      9'h012: e = '{1'b1, 6'd54};
      9'h005: e = '{1'b1, 6'd55};
      // row A15: pound(`) / . CAPS INDEX(F3) ESC SQUARE(LALT) RSHIFT
      9'h00E: e = '{1'b1, 6'd56};
      9'h04A: e = '{1'b1, 6'd57};
      9'h049: e = '{1'b1, 6'd58};
      9'h058: e = '{1'b1, 6'd59};
      9'h004: e = '{1'b1, 6'd60};
      9'h076: e = '{1'b1, 6'd61};
      9'h011: e = '{1'b1, 6'd62};
      9'h059: e = '{1'b1, 6'd63};
      default: e = '{valid: 1'b0, idx: 6'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver with parity, stop and timeout checks
module ps2_rx
  import z88_kbd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       rx_err_o
);

  localparam logic [13:0] TIMEOUT_LAST = 14'(RX_TIMEOUT - 1);

  // [0],[1] synchroniser, [2] previous synchronised value for edge detection
  logic [2:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       fall;
  logic       dat_s;

  rx_state_e   state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic        parity_q;
  logic [13:0] timer_q;
  logic [7:0]  byte_q;
  logic        byte_valid_q;
  logic        rx_err_q;

  // Bring the keyboard lines into the mck domain; idle level is high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  assign fall  = clk_sync_q[2] & ~clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Frame FSM: shift bits on each falling edge, validate at the stop bit, abandon on timeout
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RX_IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      parity_q     <= 1'b0;
      timer_q      <= 14'd0;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;

      // an edge in the timeout cycle restarts the count instead of aborting
      if (state_q == RX_IDLE || fall) begin
        timer_q <= 14'd0;
      end else if (timer_q == TIMEOUT_LAST) begin
        timer_q  <= 14'd0;
        state_q  <= RX_IDLE;
        rx_err_q <= 1'b1;
      end else begin
        timer_q <= timer_q + 14'd1;
      end

      if (fall) begin
        case (state_q)
          RX_IDLE: begin
            if (!dat_s) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= 3'd0;
              shift_q   <= 8'h00;
            end
          end
          RX_DATA: begin
            shift_q   <= {dat_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_q <= dat_s;
            state_q  <= RX_STOP;
          end
          RX_STOP: begin
            state_q <= RX_IDLE;
            if ((^{shift_q, parity_q}) && dat_s) begin
              byte_q       <= shift_q;
              byte_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign rx_err_o     = rx_err_q;

endmodule

// File: rtl/ps2_kbmat.sv
// rtl/ps2_kbmat.sv - PS/2 scancode decoder driving a Z88 8x8 key matrix; PS2_KBMAT_ERR_CLR_EN clears the matrix on receive errors
module ps2_kbmat
  import z88_kbd_pkg::*;
(
  input  logic        mck,
  input  logic        rin,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [63:0] kbmat,
  output logic        key_evt,
  output logic        rx_err
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err_w;

  logic [63:0] kbmat_q, kbmat_d;
  logic        key_evt_q, key_evt_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [2:0]  skip_q, skip_d;
  scan_ent_t   ent;

  ps2_rx u_rx (
    .clk_i        (mck),
    .rst_i        (rin),
    .ps2_clk_i    (ps2_clk),
    .ps2_dat_i    (ps2_dat),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .rx_err_o     (rx_err_w)
  );

  // Decode one received byte into flag and matrix updates
  always_comb begin
    kbmat_d = kbmat_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    skip_d  = skip_q;
    ent     = scan_lookup({ext_q, rx_byte});
    if (rx_valid) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (rx_byte)
          BYTE_EXT:   ext_d  = 1'b1;
          BYTE_BRK:   brk_d  = 1'b1;
          BYTE_PAUSE: skip_d = PAUSE_SKIP;
          BYTE_BAT_OK, BYTE_ACK, BYTE_ECHO, BYTE_BAT_NG, BYTE_RESEND: begin
          end
          BYTE_OVR0, BYTE_OVR1: begin
            kbmat_d = 64'h0;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
          default: begin
            if (ent.valid) kbmat_d[ent.idx] = ~brk_q;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
`ifdef PS2_KBMAT_ERR_CLR_EN
    else if (rx_err_w) begin
      kbmat_d = 64'h0;
    end
`endif
    key_evt_d = (kbmat_d != kbmat_q);
  end

  // Register the matrix, decoder flags and change pulse
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      kbmat_q   <= 64'h0;
      key_evt_q <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      skip_q    <= 3'd0;
    end else begin
      kbmat_q   <= kbmat_d;
      key_evt_q <= key_evt_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      skip_q    <= skip_d;
    end
  end

  assign kbmat   = kbmat_q;
  assign key_evt = key_evt_q;
  assign rx_err  = rx_err_w;

endmodule

// File: tb/tb_ps2_kbmat.sv
// tb/tb_ps2_kbmat.sv - randomized and directed bench for ps2_kbmat against a byte-level keyboard model
module tb_ps2_kbmat;

  logic        mck = 1'b0;
  logic        rin = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [63:0] kbmat;
  logic        key_evt;
  logic        rx_err;

  ps2_kbmat dut (
    .mck     (mck),
    .rin     (rin),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .kbmat   (kbmat),
    .key_evt (key_evt),
    .rx_err  (rx_err)
  );

  always #5 mck = ~mck;

  int checks = 0;
  int errors = 0;

  // keys the bench knows about: {ext, code} -> matrix bit
  localparam int NK = 12;
  bit         k_ext  [NK] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  logic [7:0] k_code [NK] = '{8'h1C, 8'h5A, 8'h75, 8'h75, 8'h1B, 8'h29,
                              8'h12, 8'h72, 8'h16, 8'h4B, 8'h66, 8'h6B};
  int         k_idx  [NK] = '{43, 6, 0, 14, 35, 46, 54, 22, 45, 41, 7, 38};
  logic [7:0] ign    [5]  = '{8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE};
  logic [7:0] unm    [3]  = '{8'h01, 8'h0B, 8'h83};

  // model state
  logic [63:0] m_kb = 64'h0;
  bit          m_ext = 0, m_brk = 0;
  int          m_skip = 0;
  bit          exp_evt = 0, exp_err = 0;
  int          m_evt_cnt = 0;
  int          evt_seen = 0, err_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge mck);
    #1;
  endtask

  function automatic int lookup(input bit e, input logic [7:0] c);
    for (int i = 0; i < NK; i++)
      if (k_ext[i] == e && k_code[i] == c) return k_idx[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_kb = 64'h0; m_ext = 0; m_brk = 0; m_skip = 0; exp_evt = 0; exp_err = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [63:0] nk;
    int ix;
    nk = m_kb;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_skip = 7;
    else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE})) begin
      if (b == 8'h00 || b == 8'hFF) nk = 64'h0;
      else begin
        ix = lookup(m_ext, b);
        if (ix >= 0) nk[ix] = !m_brk;
      end
      m_ext = 0;
      m_brk = 0;
    end
    exp_evt = (nk != m_kb);
    if (exp_evt) m_evt_cnt++;
    m_kb = nk;
  endtask

  task automatic model_err();
`ifdef PS2_KBMAT_ERR_CLR_EN
    exp_evt = (m_kb != 64'h0);
    if (exp_evt) m_evt_cnt++;
    m_kb = 64'h0;
`endif
  endtask

  // One frame; the matrix is expected to move 4 mck after the stop-bit edge is driven
  // (two synchroniser flops, the sampling cycle, then the byte_valid cycle).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bit ok;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = (~^b) ^ bad_par;
    bits[10]  = ~bad_stop;
    ok = !bad_par && !bad_stop;
    for (int i = 0; i < 11; i++) begin
      ps2_dat = bits[i];
      tick(4);
      ps2_clk = 1'b0;
      if (i == 10) begin
        tick(3);
        if (!ok) exp_err = 1;
        tick(1);
        exp_err = 0;
        if (ok) model_byte(b); else model_err();
        tick(1);
        exp_evt = 0;
        tick(3);
      end else begin
        tick(8);
      end
      ps2_clk = 1'b1;
      tick(4);
    end
    ps2_dat = 1'b1;
    tick(6);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  // start bit plus nbits data bits, then the line goes quiet
  task automatic send_partial(input int nbits, input logic [7:0] b);
    for (int i = 0; i <= nbits; i++) begin
      ps2_dat = (i == 0) ? 1'b0 : b[i-1];
      tick(4);
      ps2_clk = 1'b0;
      tick(8);
      ps2_clk = 1'b1;
      tick(4);
    end
  endtask

  // Cycle-by-cycle comparison of all outputs against the model
  always @(negedge mck) begin
    chk("kbmat", kbmat, m_kb);
    chk("key_evt", {63'h0, key_evt}, {63'h0, exp_evt});
    chk("rx_err", {63'h0, rx_err}, {63'h0, exp_err});
    if (key_evt) evt_seen++;
    if (rx_err) err_seen++;
  end

  initial begin
    int e0;
    int r0;
    logic [7:0] rb;

    // reset
    tick(3);
    chk("reset_kbmat", kbmat, 64'h0);
    chk("reset_evt_err", {62'h0, key_evt, rx_err}, 64'h0);
    rin = 1'b0;
    tick(5);

    // make A, then break A
    e0 = evt_seen;
    send_byte(8'h1C);
    chk("make_A", kbmat, 64'h0000_0800_0000_0000);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("break_A", kbmat, 64'h0);
    chk("A_evt_count", 64'(evt_seen - e0), 64'd2);

    // extended up arrow vs keypad 8
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'h75);
    chk("up_and_kp8", kbmat, 64'h0000_0000_0000_4001);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk("break_up_only", kbmat, 64'h0000_0000_0000_0001);
    send_byte(8'hF0);
    send_byte(8'h75);

    // parity error with A held
    send_byte(8'h1C);
    r0 = err_seen;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("parity_err_count", 64'(err_seen - r0), 64'd1);
`ifdef PS2_KBMAT_ERR_CLR_EN
    chk("parity_err_kbmat", kbmat, 64'h0);
`else
    chk("parity_err_kbmat", kbmat, 64'h0000_0800_0000_0000);
`endif
    send_byte(8'hF0);
    send_byte(8'h1C);

    // timeout after start + 4 data bits
    r0 = err_seen;
    send_partial(4, 8'h1C);
    ps2_dat = 1'b1;
    tick(9000);
    chk("no_early_timeout", 64'(err_seen - r0), 64'd0);
    tick(991);
    exp_err = 1;
    tick(1);
    exp_err = 0;
    model_err();
    tick(1);
    exp_evt = 0;
    tick(10);
    chk("timeout_err_count", 64'(err_seen - r0), 64'd1);
    send_byte(8'h1C);
    chk("after_timeout_A", kbmat, 64'h0000_0800_0000_0000);

    // A + Enter, then overrun clears everything with one event
    send_byte(8'h5A);
    chk("A_enter", kbmat, 64'h0000_0800_0000_0040);
    e0 = evt_seen;
    send_byte(8'hFF);
    chk("overrun_clear", kbmat, 64'h0);
    chk("overrun_evt", 64'(evt_seen - e0), 64'd1);
    e0 = evt_seen;
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    chk("typematic_evt", 64'(evt_seen - e0), 64'd1);

    // reset mid-frame with A held
    send_partial(3, 8'h5A);
    tick(2);
    rin = 1'b1;
    model_reset();
    tick(2);
    chk("midframe_reset", kbmat, 64'h0);
    rin = 1'b0;
    ps2_dat = 1'b1;
    ps2_clk = 1'b1;
    tick(10);

    // pause sequence is swallowed whole
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    send_byte(8'h1C);
    chk("pause_then_A", kbmat, 64'h0000_0800_0000_0000);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int r;
      int k;
      r = $urandom_range(0, 99);
      k = $urandom_range(0, NK - 1);
      if (r < 45) begin
        if (k_ext[k]) send_byte(8'hE0);
        send_byte(k_code[k]);
      end else if (r < 70) begin
        if (k_ext[k]) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(k_code[k]);
      end else if (r < 74) begin
        send_byte(r[0] ? 8'hFF : 8'h00);
      end else if (r < 79) begin
        send_byte(ign[$urandom_range(0, 4)]);
      end else if (r < 85) begin
        send_byte(unm[$urandom_range(0, 2)]);
      end else if (r < 92) begin
        rb = 8'($urandom);
        send_frame(rb, r[0], !r[0]);
      end else if (r < 96) begin
        send_byte(8'hE1);
        for (int j = 0; j < 7; j++) begin
          rb = 8'($urandom);
          send_byte(rb);
        end
      end else begin
        send_byte(8'hE0);
        send_byte(8'h1C);
      end
    end
    tick(20);
    chk("total_evt_count", 64'(evt_seen), 64'(m_evt_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_kbmat.md
PS2_KBMAT -- requirements
Module: ps2_kbmat

Interface
REQ-001 SHALL have port mck, input, 1, 9.83 MHz master clock; the only clock; all state changes on its rising edge.
REQ-002 SHALL have port rin, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port ps2_clk, input, 1, PS/2 keyboard clock, asynchronous to mck.
REQ-004 SHALL have port ps2_dat, input, 1, PS/2 keyboard data, asynchronous to mck.
REQ-005 SHALL have port kbmat, output, 64, key matrix; bit 8*r+c = 1 means row r (selected by address line A8+r), column c (data bit c) is pressed.
REQ-006 SHALL have port key_evt, output, 1, one-cycle pulse on every kbmat change.
REQ-007 SHALL have port rx_err, output, 1, one-cycle pulse on a parity, stop or timeout error.

Function
REQ-008 SHALL pass ps2_clk and ps2_dat through 2-flop synchronisers; a falling edge is the synchronised clock going 1->0.
REQ-009 SHALL run a receiver FSM with states IDLE, DATA, PARITY, STOP:
- IDLE->DATA on an edge with dat=0.
- DATA shifts 8 bits LSB first, then ->PARITY.
- PARITY samples the parity bit, then ->STOP.
- STOP samples the stop bit, then ->IDLE.
REQ-010 SHALL accept a frame only if data plus parity has odd parity and stop=1; otherwise pulse rx_err and discard the byte.
REQ-011 SHALL return to IDLE from a non-IDLE state and pulse rx_err after 10000 mck cycles without an edge (14-bit counter, cleared on each edge); an edge in the same cycle as the timeout wins.
REQ-012 SHALL assert byte_valid one cycle after the stop bit is sampled; kbmat and key_evt SHALL update on the next cycle (total latency 2 mck).
REQ-013 SHALL run a decoder with flags ext and brk:
- 0xE0 sets ext.
- 0xF0 sets brk.
- 0xE1 loads skip=7; the next 7 bytes are ignored.
- Any other byte is looked up as {ext, code} in a 512-entry table giving a valid bit and a 6-bit index.
REQ-014 SHALL, on a valid lookup, set kbmat[index] on make (brk=0) and clear it on break (brk=1); key_evt SHALL pulse only if the bit actually changes.
REQ-015 SHALL clear ext and brk after every non-prefix byte, including unmapped codes, which otherwise change nothing.
REQ-016 SHALL clear all of kbmat, pulsing key_evt if it was non-zero, on byte 0x00 or 0xFF (keyboard overrun).
REQ-017 SHALL ignore bytes 0xAA, 0xFA, 0xEE, 0xFC, 0xFE (no state change, flags kept).
REQ-018 SHALL apply repeated make codes (typematic) idempotently with no key_evt.

Reset
REQ-019 SHALL, while rin=1, force receiver FSM=IDLE, shift register=0, timeout counter=0, ext=brk=0, skip=0, kbmat=64'h0, key_evt=0, rx_err=0.
REQ-020 SHALL drop a frame in progress when rin asserts mid-frame, and resume on the next start bit after release.

Configuration
REQ-021 SHALL, with PS2_KBMAT_ERR_CLR_EN defined, clear all of kbmat in the cycle after any rx_err pulse (key_evt if non-zero); without it, rx_err leaves kbmat untouched.

Structure
REQ-022 SHALL place the receiver state enum, the timeout constant (10000), the prefix/special byte constants and the {ext,code}->index scancode table in shared package z88_kbd_pkg.
REQ-023 SHALL implement the receiver (REQ-008..012) as sub-module ps2_rx, with outputs byte, byte_valid and rx_err; decoding and matrix storage live in ps2_kbmat.

Verification
REQ-024 SHALL cover: frame 0x1C, parity 0, stop 1, then F0 1C -> kbmat bit for 'A' rises 2 mck after the first stop bit and falls after the break; key_evt pulses twice.
REQ-025 SHALL cover: E0 75 (up arrow) vs 75 (keypad 8) -> distinct table indices set; E0 F0 75 clears only the up-arrow bit.
REQ-026 SHALL cover: frame 0x1C with parity 1 -> rx_err pulses once, kbmat unchanged; with PS2_KBMAT_ERR_CLR_EN and a key held -> kbmat=0.
REQ-027 SHALL cover: start plus 4 data bits, then idle 10000 mck -> rx_err pulse, FSM=IDLE; a following valid 0x1C is accepted.
REQ-028 SHALL cover: keys A and Enter held, then byte 0xFF -> kbmat=0, single key_evt; 1C 1C 1C -> one key_evt only.
REQ-029 SHALL cover: rin pulsed mid-frame -> all outputs 0; E1 14 77 E1 F0 14 F0 77 followed by 1C -> only the 'A' bit set.
